// File: rtl/mips_pkg.sv
// Shared MIPS constants: register indices and datapath widths.
// Imported by the register file, control unit and destination select.
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 5;

  localparam logic [31:0] MIPS_SP_INIT = 32'h0000_0FFC;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: 2 async reads, 1 sync write.
// Ports: clk, rst (sync, active-high); rs/rt read ports; wr_* write
// port; dbg_addr/dbg_data debug read; wr_count saturating write count.
module mips_regfile
  import mips_pkg::*;
#(
  parameter int                DATA_W  = MIPS_DATA_W,
  parameter int                ADDR_W  = MIPS_ADDR_W,
  parameter logic [DATA_W-1:0] SP_INIT = MIPS_SP_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [15:0]       wr_count
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREG];
  logic              wr_fire;

  // Writes to $zero are dropped and do not count.
  assign wr_fire = wr_en && (wr_addr != ZERO_IDX);

  // Cell 0 is never written; index 0 is forced to zero on every port
  // so the read never depends on its contents.
  assign rs_data  = (rs_addr == ZERO_IDX) ? '0 : regs[rs_addr];
  assign rt_data  = (rt_addr == ZERO_IDX) ? '0 : regs[rt_addr];
  assign dbg_data = (dbg_addr == ZERO_IDX) ? '0 : regs[dbg_addr];

  // No write-to-read bypass: rs_data feeds back into wr_data through
  // the ALU in a single-cycle core, so a bypass would close a loop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (wr_fire && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile.
// Directed scenarios plus random traffic against an array model.
module tb_mips_regfile;

  localparam logic [31:0] SP = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs_addr = '0;
  logic [4:0]  rt_addr = '0;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;
  logic [15:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [32];
  int          mcount;

  always #5 clk = ~clk;

  mips_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .wr_count (wr_count)
  );

  // One rising edge; the model applies the architectural rules
  // to the inputs that were present at that edge.
  task automatic tick();
    logic        r;
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    r  = rst;
    we = wr_en;
    a  = wr_addr;
    d  = wr_data;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      model[29] = SP;
      mcount = 0;
    end else if (we && a != 5'd0) begin
      model[a] = d;
      if (mcount < 65535) mcount++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wr_en = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] exp;
      dbg_addr = 5'(i);
      #1;
      exp = (i == 29) ? SP : 32'h0;
      n_tests++;
      if (dbg_data !== exp) begin
        $display("FAIL reset_reg[%0d] got %h want %h",
                 i, dbg_data, exp);
        n_fail++;
      end
    end
    n_tests++;
    if (wr_count !== 16'd0) begin
      $display("FAIL reset_count got %h want 0", wr_count);
      n_fail++;
    end
  endtask

  task automatic test_basic();
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEAD_BEEF;
    tick();
    wr_en = 1'b0;
    rs_addr = 5'd5;
    rt_addr = 5'd5;
    dbg_addr = 5'd5;
    #1;
    n_tests++;
    if (rs_data !== 32'hDEAD_BEEF) begin
      $display("FAIL basic_rs got %h want deadbeef", rs_data);
      n_fail++;
    end
    n_tests++;
    if (rt_data !== 32'hDEAD_BEEF) begin
      $display("FAIL basic_rt got %h want deadbeef", rt_data);
      n_fail++;
    end
    n_tests++;
    if (dbg_data !== 32'hDEAD_BEEF) begin
      $display("FAIL basic_dbg got %h want deadbeef", dbg_data);
      n_fail++;
    end
    n_tests++;
    if (wr_count !== 16'd1) begin
      $display("FAIL basic_count got %0d want 1", wr_count);
      n_fail++;
    end
  endtask

  task automatic test_zero();
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFF_FFFF;
    tick();
    wr_en = 1'b0;
    rs_addr = 5'd0;
    rt_addr = 5'd0;
    #1;
    n_tests++;
    if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
      $display("FAIL zero_read got %h/%h want 0", rs_data, rt_data);
      n_fail++;
    end
    n_tests++;
    if (wr_count !== 16'd1) begin
      $display("FAIL zero_count got %0d want 1", wr_count);
      n_fail++;
    end
  endtask

  task automatic test_no_bypass();
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h11;
    tick();
    rs_addr = 5'd7;
    wr_data = 32'h22;
    #1;
    n_tests++;
    if (rs_data !== 32'h11) begin
      $display("FAIL bypass_before got %h want 11", rs_data);
      n_fail++;
    end
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (rs_data !== 32'h22) begin
      $display("FAIL bypass_after got %h want 22", rs_data);
      n_fail++;
    end
  endtask

  task automatic test_reset_vs_write();
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'h1234_5678;
    tick();
    rst = 1'b1;
    wr_data = 32'hA5A5_A5A5;
    tick();
    rst = 1'b0;
    wr_en = 1'b0;
    rs_addr = 5'd3;
    rt_addr = 5'd29;
    #1;
    n_tests++;
    if (rs_data !== 32'h0) begin
      $display("FAIL rstwr_reg3 got %h want 0", rs_data);
      n_fail++;
    end
    n_tests++;
    if (rt_data !== SP) begin
      $display("FAIL rstwr_sp got %h want %h", rt_data, SP);
      n_fail++;
    end
    n_tests++;
    if (wr_count !== 16'd0) begin
      $display("FAIL rstwr_count got %0d want 0", wr_count);
      n_fail++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 59) == 0);
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs_addr  = 5'($urandom_range(0, 31));
      rt_addr  = ($urandom_range(0, 3) == 0) ? wr_addr
                                             : 5'($urandom_range(0, 31));
      dbg_addr = ($urandom_range(0, 3) == 0) ? rs_addr
                                             : 5'($urandom_range(0, 31));
      #1;
      n_tests++;
      if (rs_data !== model[rs_addr]) begin
        $display("FAIL rand_rs[%0d] got %h want %h",
                 rs_addr, rs_data, model[rs_addr]);
        n_fail++;
      end
      n_tests++;
      if (rt_data !== model[rt_addr]) begin
        $display("FAIL rand_rt[%0d] got %h want %h",
                 rt_addr, rt_data, model[rt_addr]);
        n_fail++;
      end
      n_tests++;
      if (dbg_data !== model[dbg_addr]) begin
        $display("FAIL rand_dbg[%0d] got %h want %h",
                 dbg_addr, dbg_data, model[dbg_addr]);
        n_fail++;
      end
      tick();
      n_tests++;
      if (wr_count !== 16'(mcount)) begin
        $display("FAIL rand_count got %0d want %0d", wr_count, mcount);
        n_fail++;
      end
    end
    rst = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd1;
    for (int i = 0; i < 65535; i++) begin
      wr_data = 32'(i);
      tick();
    end
    n_tests++;
    if (wr_count !== 16'hFFFF) begin
      $display("FAIL sat_preload got %h want ffff", wr_count);
      n_fail++;
    end
    wr_data = 32'hCAFE_F00D;
    tick();
    wr_en = 1'b0;
    dbg_addr = 5'd1;
    #1;
    n_tests++;
    if (wr_count !== 16'hFFFF) begin
      $display("FAIL sat_hold got %h want ffff", wr_count);
      n_fail++;
    end
    n_tests++;
    if (dbg_data !== 32'hCAFE_F00D) begin
      $display("FAIL sat_reg1 got %h want cafef00d", dbg_data);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_no_bypass();
    test_reset_vs_write();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
